// File: rtl/iir_pkg.sv
// Shared types and defaults for the IIR sample fetch front end.
package iir_pkg;

   localparam int unsigned DEF_ADDR_W = 20;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;

   typedef logic [DEF_DATA_W-1:0] sample_t;

endpackage

// File: rtl/iir_fifo.sv
// Synchronous FIFO; the head entry is presented directly from storage and
// reads as zero while the FIFO is empty.
module iir_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 17,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = count_q;
   assign rdata   = empty ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wptr_q <= wptr_q + PW'(1);
         end
         if (do_pop) begin
            rptr_q <= rptr_q + PW'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + CW'(1);
         end else if (!do_push && do_pop) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

endmodule

// File: rtl/iir_sample_fetch.sv
// Streams samples from the sample ROM into a FIFO and presents them to the
// filter core as a valid/ready stream with an end-of-stream marker.
module iir_sample_fetch
   import iir_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              load,
   output logic [ADDR_W-1:0] RAddr,
   input  logic [DATA_W-1:0] DIn,
   input  logic              data_done,
   output logic              s_valid,
   input  logic              s_ready,
   output logic [DATA_W-1:0] s_data,
   output logic              s_last,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] raddr_q;
   logic              busy_q;
   logic              done_q;

   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic              unused_fifo_full;
   logic [DATA_W:0]   head;
   logic              pop;

   // Gated by the registered count only, so a same-cycle pop never unlocks a read.
   assign load    = (state_q == FETCH) && (fifo_count < CW'(DEPTH));
   assign s_valid = !fifo_empty;
   assign s_data  = head[DATA_W-1:0];
   assign s_last  = head[DATA_W];
   assign pop     = s_valid && s_ready;
   assign RAddr   = raddr_q;
   assign busy    = busy_q;
   assign done    = done_q;

   iir_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W + 1)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (load),
      .wdata ({data_done, DIn}),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (unused_fifo_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         raddr_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= FETCH;
                  raddr_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            FETCH: begin
               if (load) begin
                  raddr_q <= raddr_q + ADDR_W'(1);
                  if (data_done) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && s_last) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
